// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and width helper for the RAM arbiter
// Contents:
//   ramstate_t  : RAM handshake state reported by the RAM model
//   arb_state_t : arbiter FSM states
//   src_kind_t  : source kind of a grant (instruction or data)
//   idx_width() : index width for N requesters, never below 1 bit
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_kind_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - core-side and RAM-side bus bundle of the RAM arbiter
// Signals:
//   iREN/iaddr, dREN/dWEN/daddr/dstore : per-core requests (to arbiter)
//   iwait/dwait, iload/dload           : per-core completion and read data
//   ramstate/ramload                   : RAM status and read data
//   ramaddr/ramstore/ramREN/ramWEN     : RAM command port
// Modports: slave = arbiter side, master = cores + RAM side.
interface ram_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    import ram_arbiter_pkg::*;

    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0][ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][ADDR_W-1:0] daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][WORD_W-1:0] iload;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    ramstate_t                   ramstate;
    logic [WORD_W-1:0]           ramload;
    logic [ADDR_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic                        ramREN;
    logic                        ramWEN;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rtl/ram_arbiter_rr_pick.sv - round-robin picker over N request lines
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index granted last; search starts at ptr+1 (mod N)
//   gnt   out N   one-hot grant
//   idx   out IW  index of the granted line
//   valid out 1   at least one request present
module rr_pick
    import ram_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Two passes replace a modular rotate: first the lines above ptr, then
    // wrap around to lines 0..ptr. The first hit in that order wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) > ptr)) begin
                valid  = 1'b1;
                idx    = IW'(i);
                gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) <= ptr)) begin
                valid  = 1'b1;
                idx    = IW'(i);
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - locks one core's instruction or data request onto the RAM port
// Ports:
//   CLK  in  clock
//   RST  in  asynchronous active-high reset
//   bus  slave modport of ram_arbiter_if (core requests, waits/loads, RAM port)
// Data beats instruction, except when STARVE_MAX data grants have completed
// while an instruction was waiting. Each kind rotates round-robin on its own.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS       = 2,
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.slave  bus
);

    localparam int IW = idx_width(CPUS);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    arb_state_t      state_q, state_d;
    src_kind_t       kind_q, kind_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CPUS-1:0] oh_q, oh_d;
    logic            wr_q, wr_d;
    logic [IW-1:0]   iptr_q, iptr_d;
    logic [IW-1:0]   dptr_q, dptr_d;
    logic [CW-1:0]   starve_q, starve_d;

    logic [CPUS-1:0] ireq, dreq;
    logic [CPUS-1:0] i_gnt, d_gnt;
    logic [IW-1:0]   i_idx, d_idx;
    logic            i_valid, d_valid;
    logic            grant_active;

    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_store;

    assign ireq = bus.iREN;
    assign dreq = bus.dREN | bus.dWEN;

    rr_pick #(.N(CPUS)) u_ipick (
        .req   (ireq),
        .ptr   (iptr_q),
        .gnt   (i_gnt),
        .idx   (i_idx),
        .valid (i_valid)
    );

    rr_pick #(.N(CPUS)) u_dpick (
        .req   (dreq),
        .ptr   (dptr_q),
        .gnt   (d_gnt),
        .idx   (d_idx),
        .valid (d_valid)
    );

    // The granted core still holding its request; used to detect withdrawal.
    assign grant_active = (kind_q == SRC_I) ? |(oh_q & ireq) : |(oh_q & dreq);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ARB;
            kind_q   <= SRC_I;
            idx_q    <= '0;
            oh_q     <= '0;
            wr_q     <= 1'b0;
            iptr_q   <= IW'(CPUS - 1);
            dptr_q   <= IW'(CPUS - 1);
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            idx_q    <= idx_d;
            oh_q     <= oh_d;
            wr_q     <= wr_d;
            iptr_q   <= iptr_d;
            dptr_q   <= dptr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        idx_d    = idx_q;
        oh_d     = oh_q;
        wr_d     = wr_q;
        iptr_d   = iptr_q;
        dptr_d   = dptr_q;
        starve_d = starve_q;
        case (state_q)
            ARB: begin
                if (i_valid && (starve_q == STARVE_TOP)) begin
                    kind_d  = SRC_I;
                    idx_d   = i_idx;
                    oh_d    = i_gnt;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end else if (d_valid) begin
                    kind_d  = SRC_D;
                    idx_d   = d_idx;
                    oh_d    = d_gnt;
                    // Write is latched at grant so the RAM strobes never
                    // follow the request lines combinationally.
                    wr_d    = |(d_gnt & bus.dWEN);
                    state_d = XFER;
                end else if (i_valid) begin
                    kind_d  = SRC_I;
                    idx_d   = i_idx;
                    oh_d    = i_gnt;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (bus.ramstate == ACCESS) begin
                    state_d = ARB;
                    if (kind_q == SRC_I) begin
                        iptr_d   = idx_q;
                        starve_d = '0;
                    end else begin
                        dptr_d = idx_q;
                        if ((|ireq) && (starve_q != STARVE_TOP)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end else if (!grant_active) begin
                    // Withdrawn before completion: abandon without touching
                    // pointers or the starvation count.
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        bus.iwait  = '1;
        bus.dwait  = '1;
        bus.iload  = '0;
        bus.dload  = '0;
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        sel_addr   = '0;
        sel_store  = '0;
        if (state_q == XFER) begin
            if (kind_q == SRC_I) begin
                sel_addr   = bus.iaddr[idx_q];
                bus.ramREN = 1'b1;
            end else begin
                sel_addr   = bus.daddr[idx_q];
                sel_store  = bus.dstore[idx_q];
                bus.ramREN = !wr_q;
                bus.ramWEN = wr_q;
            end
            if (bus.ramstate == ACCESS) begin
                for (int c = 0; c < CPUS; c++) begin
                    if (oh_q[c]) begin
                        if (kind_q == SRC_I) begin
                            bus.iwait[c] = 1'b0;
                            bus.iload[c] = bus.ramload;
                        end else begin
                            bus.dwait[c] = 1'b0;
                            bus.dload[c] = bus.ramload;
                        end
                    end
                end
            end
        end
        bus.ramaddr  = sel_addr;
        bus.ramstore = sel_store;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    ram_arbiter_if #(.CPUS(2), .ADDR_W(32), .WORD_W(32)) bus();

    ram_arbiter #(
        .CPUS       (2),
        .ADDR_W     (32),
        .WORD_W     (32),
        .STARVE_MAX (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = '0;
        bus.dREN     = '0;
        bus.dWEN     = '0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 001111", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        n_cmp++;
        if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: ramaddr=%h ramstore=%h not zero", bus.ramaddr, bus.ramstore);
        end
        RST = 1'b0;
        step();
        step();
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 6'b00_11_11) begin
            n_bad++;
            $display("FAIL idle_no_req: got %b want 001111", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        bus.dWEN[0]  = 1'b1;
        bus.daddr[0] = 32'h80;
        bus.ramstate = BUSY;
        step();
        n_cmp++;
        if (bus.ramWEN !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_wen: got %b want 1", bus.ramWEN);
        end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.dwait, bus.ramaddr} !== {4'b0011, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_mid_xfer: ren=%b wen=%b dwait=%b addr=%h want 0 0 11 0", bus.ramREN, bus.ramWEN, bus.dwait, bus.ramaddr);
        end
        step();
        clear_inputs();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_ifetch();
        apply_reset();
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        bus.ramload  = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.iwait} !== 3'b0_11) begin
            n_bad++;
            $display("FAIL ifetch_c0: ren=%b iwait=%b want 0 11", bus.ramREN, bus.iwait);
        end
        step();
        bus.ramstate = BUSY;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.ramaddr} !== {4'b10_11, 32'h40}) begin
            n_bad++;
            $display("FAIL ifetch_c1: ren=%b wen=%b iwait=%b addr=%h want 1 0 11 40", bus.ramREN, bus.ramWEN, bus.iwait, bus.ramaddr);
        end
        step();
        bus.ramstate = ACCESS;
        #1;
        n_cmp++;
        if ({bus.iwait, bus.dwait} !== 4'b10_11) begin
            n_bad++;
            $display("FAIL ifetch_c2_wait: iwait=%b dwait=%b want 10 11", bus.iwait, bus.dwait);
        end
        n_cmp++;
        if ({bus.iload[1], bus.iload[0]} !== {32'h0, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL ifetch_c2_load: iload1=%h iload0=%h want 0 deadbeef", bus.iload[1], bus.iload[0]);
        end
        step();
        bus.iREN     = '0;
        bus.ramstate = FREE;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.iwait, bus.iload} !== {3'b0_11, 64'h0}) begin
            n_bad++;
            $display("FAIL ifetch_c3: ren=%b iwait=%b want 0 11 and zero loads", bus.ramREN, bus.iwait);
        end
    endtask

    task automatic test_data_priority();
        apply_reset();
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h80;
        bus.dstore[0] = 32'h1234;
        bus.iREN[1]   = 1'b1;
        bus.iaddr[1]  = 32'h100;
        bus.ramstate  = BUSY;
        bus.ramload   = 32'hCAFE0001;
        step();
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.ramstore, bus.ramaddr} !== {2'b01, 32'h1234, 32'h80}) begin
            n_bad++;
            $display("FAIL prio_write: ren=%b wen=%b store=%h addr=%h want 0 1 1234 80", bus.ramREN, bus.ramWEN, bus.ramstore, bus.ramaddr);
        end
        step();
        n_cmp++;
        if (bus.ramaddr !== 32'h80) begin
            n_bad++;
            $display("FAIL prio_addr_hold: got %h want 80", bus.ramaddr);
        end
        bus.ramstate = ACCESS;
        #1;
        n_cmp++;
        if ({bus.dwait, bus.iwait, bus.dload[0]} !== {4'b10_11, 32'hCAFE0001}) begin
            n_bad++;
            $display("FAIL prio_dcomplete: dwait=%b iwait=%b dload0=%h want 10 11 cafe0001", bus.dwait, bus.iwait, bus.dload[0]);
        end
        step();
        bus.dWEN     = '0;
        bus.ramstate = FREE;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr} !== {2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL prio_bubble: ren=%b wen=%b addr=%h want 0 0 0", bus.ramREN, bus.ramWEN, bus.ramaddr);
        end
        step();
        bus.ramstate = ACCESS;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload[1]} !== {1'b1, 32'h100, 2'b01, 32'hCAFE0001}) begin
            n_bad++;
            $display("FAIL prio_ifetch: ren=%b addr=%h iwait=%b iload1=%h want 1 100 01 cafe0001", bus.ramREN, bus.ramaddr, bus.iwait, bus.iload[1]);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_rr_data();
        int w;
        logic [31:0] want_addr;
        logic [1:0]  want_dwait;
        apply_reset();
        bus.dREN     = 2'b11;
        bus.daddr[0] = 32'h200;
        bus.daddr[1] = 32'h300;
        bus.ramstate = ACCESS;
        #1;
        for (int k = 0; k < 6; k++) begin
            want_addr  = k[0] ? 32'h300 : 32'h200;
            want_dwait = k[0] ? 2'b01 : 2'b10;
            w = 0;
            do begin
                step();
                w++;
            end while (!bus.ramREN && (w < 4));
            n_cmp++;
            if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, want_addr, want_dwait}) begin
                n_bad++;
                $display("FAIL rr_grant%0d: ren=%b addr=%h dwait=%b want 1 %h %b", k, bus.ramREN, bus.ramaddr, bus.dwait, want_addr, want_dwait);
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_starvation();
        int w;
        logic [3:0]  exp_w [6] = '{4'b11_10, 4'b11_01, 4'b01_11, 4'b11_10, 4'b11_01, 4'b01_11};
        logic [31:0] exp_a [6] = '{32'h200, 32'h300, 32'h700, 32'h200, 32'h300, 32'h700};
        apply_reset();
        bus.dREN     = 2'b11;
        bus.daddr[0] = 32'h200;
        bus.daddr[1] = 32'h300;
        bus.iREN[1]  = 1'b1;
        bus.iaddr[1] = 32'h700;
        bus.ramstate = ACCESS;
        #1;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            do begin
                step();
                w++;
            end while (!bus.ramREN && (w < 4));
            n_cmp++;
            if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {1'b1, exp_w[k], exp_a[k]}) begin
                n_bad++;
                $display("FAIL starve_grant%0d: ren=%b iwait=%b dwait=%b addr=%h want 1 %b %h", k, bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr, exp_w[k], exp_a[k]);
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_withdraw_error();
        apply_reset();
        bus.dREN     = 2'b11;
        bus.daddr[0] = 32'h10;
        bus.daddr[1] = 32'h20;
        bus.ramstate = BUSY;
        bus.ramload  = 32'h77;
        step();
        n_cmp++;
        if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL wd_first: ren=%b addr=%h want 1 10", bus.ramREN, bus.ramaddr);
        end
        bus.dREN[0] = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.dwait} !== 3'b1_11) begin
            n_bad++;
            $display("FAIL wd_same_cycle: ren=%b dwait=%b want 1 11", bus.ramREN, bus.dwait);
        end
        step();
        n_cmp++;
        if ({bus.ramREN, bus.dwait} !== 3'b0_11) begin
            n_bad++;
            $display("FAIL wd_dropped: ren=%b dwait=%b want 0 11", bus.ramREN, bus.dwait);
        end
        step();
        bus.ramstate = ERROR;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            #1;
            n_cmp++;
            if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, 32'h20, 2'b11}) begin
                n_bad++;
                $display("FAIL err_hold%0d: ren=%b addr=%h dwait=%b want 1 20 11", k, bus.ramREN, bus.ramaddr, bus.dwait);
            end
        end
        step();
        bus.ramstate = ACCESS;
        #1;
        n_cmp++;
        if ({bus.dwait, bus.dload[1], bus.dload[0]} !== {2'b01, 32'h77, 32'h0}) begin
            n_bad++;
            $display("FAIL err_complete: dwait=%b dload1=%h dload0=%h want 01 77 0", bus.dwait, bus.dload[1], bus.dload[0]);
        end
        step();
        bus.dREN     = '0;
        bus.ramstate = FREE;
        #1;
        n_cmp++;
        if ({bus.ramREN, bus.dwait} !== 3'b0_11) begin
            n_bad++;
            $display("FAIL err_single: ren=%b dwait=%b want 0 11", bus.ramREN, bus.dwait);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ifetch();
        test_data_priority();
        test_rr_data();
        test_starvation();
        test_withdraw_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised successor to the single/dual-CPU memory controller arbitration path. Arbitrates instruction and data requests from `CPUS` cores onto one shared RAM port. Grants are locked for a whole RAM transaction, with separate round-robin rotation among data requesters and among instruction requesters, data-over-instruction priority, and a starvation limit that forces an instruction grant. Sits between the per-core cache/bus controllers and the RAM model; coherence stays upstream.

## Interface
- `CPUS`, 2, number of cores (≥1).
- `ADDR_W`, 32, RAM word-address width.
- `WORD_W`, 32, data word width.
- `STARVE_MAX`, 4, consecutive data grants after which a pending instruction request wins (≥1).
- `CLK`  in  1  clock; one clock.
- `RST`  in  1  reset; reset is asynchronous and active-high.
- `iREN`  in  CPUS  instruction read request per core.
- `iaddr`  in  CPUS×ADDR_W  instruction address per core.
- `dREN`, `dWEN`  in  CPUS each  data read/write request per core (dWEN wins if both).
- `daddr`  in  CPUS×ADDR_W  data address per core.
- `dstore`  in  CPUS×WORD_W  write data per core.
- `iwait`, `dwait`  out  CPUS each  1 = not complete; 0 for exactly the completing cycle.
- `iload`, `dload`  out  CPUS×WORD_W  ramload routed to the granted source, else 0.
- `ramstate`  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM.
- `ramload`  in  WORD_W  RAM read data.
- `ramaddr`  out  ADDR_W; `ramstore`  out  WORD_W; `ramREN`, `ramWEN`  out  1.

## Operation
- FSM states: ARB, XFER.
- ARB: no RAM strobes. Pick a winner from the current requests (combinational), register the grant (source kind I/D, core index), then go to XFER. If no request is pending, stay in ARB.
- Priority:
  - If any instruction request is pending and `starve_cnt == STARVE_MAX`, an instruction request wins.
  - Otherwise any data request beats any instruction request.
  - Within a kind, selection is round-robin starting at `ptr_kind + 1` (mod CPUS).
- XFER: drive `ramaddr`/`ramREN`/`ramWEN`/`ramstore` from the granted source only. Requests from other sources are ignored and their wait stays 1.
- Completion: in XFER with `ramstate == ACCESS`:
  - Granted wait = 0 and its load = ramload, for that cycle only.
  - Update that kind's pointer to the granted index.
  - Data grant: `starve_cnt += 1` if an instruction request is pending (saturates at STARVE_MAX). Instruction grant: `starve_cnt` clears to 0.
  - Return to ARB.
- Withdrawal: if the granted request deasserts during XFER before ACCESS, abort. Drop the strobes next cycle, return to ARB, and leave the pointer and counter unchanged.
- ERROR or BUSY: hold the grant and strobes and keep waiting. Retry is implicit.
- Reset values: state = ARB; pointers = CPUS-1, so core 0 is first; starve_cnt = 0. All waits = 1; all loads, ramaddr, ramstore = 0; ramREN = ramWEN = 0.

## Timing
- Request seen in cycle t: strobes are asserted from t+1. With RAM ACCESS in cycle t+k (k≥1), wait drops in t+k and the next grant's strobes start at t+k+2.
- All outputs are combinational from the registered grant, state and ramstate. There is no combinational path from request inputs to RAM outputs.
- Reset asserted mid-XFER: strobes drop and waits go to 1 immediately (asynchronous). The transaction is lost and must be reissued after reset.
- Single requester: back-to-back same-source transactions incur one ARB bubble each.
- CPUS = 1: both pointers are stuck at 0. The starvation rule still applies.

## Structure
- `cpu_types_pkg` additions:
  - `arb_state_t` {ARB, XFER}.
  - `src_kind_t` {SRC_I, SRC_D}.
  - Widths derived from `$clog2(CPUS)`, minimum 1 bit.
- Sub-module `rr_pick` (parameter N): inputs request vector and pointer; outputs one-hot grant, index, and valid. Instantiate one for instruction and one for data.

## Test plan
- Reset, CPUS=2, no requests: all waits = 1, ramREN = ramWEN = 0, ramaddr = 0. Assert RST mid-XFER: strobes = 0 the same cycle.
- Core0 iREN, iaddr = 0x40, RAM latency 2: ramREN high from cycle 1; `iwait[0]` = 0 only in cycle 2, with iload = ramload = 0xDEADBEEF.
- Core0 dWEN (daddr = 0x80, dstore = 0x1234) and core1 iREN in the same cycle: data is granted first. ramWEN = 1, ramstore = 0x1234, and iaddr[1] never drives ramaddr until the data grant completes.
- Both cores assert dREN continuously, 6 completions: grants alternate 0,1,0,1,0,1.
- STARVE_MAX = 2: continuous data requests plus a pending core1 iREN. The instruction is granted after exactly 2 data completions, then starve_cnt = 0.
- Granted dREN withdrawn before ACCESS: return to ARB, pointer unchanged, the other pending request is granted next. ramstate = ERROR for 3 cycles then ACCESS: strobes are held throughout and a single completion is reported.
